// File: rtl/sync_fifo_pkg.sv
// Shared constants and types for the single-clock FIFO and its storage array.
package sync_fifo_pkg;

    localparam string FT_TRUE  = "TRUE";
    localparam string FT_FALSE = "FALSE";

    function automatic int fifo_depth(input int asize);
        return 1 << asize;
    endfunction

    typedef struct packed {
        logic full;
        logic afull;
        logic empty;
        logic aempty;
    } fifo_flags_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo: one write port and one read port, either
// fall-through (combinational head word) or registered (updated on pop).
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int    DSIZE       = 8,
    parameter int    ASIZE       = 4,
    parameter string FALLTHROUGH = FT_TRUE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [ASIZE-1:0] waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic             re,
    input  logic [ASIZE-1:0] raddr,
    output logic [DSIZE-1:0] rdata
);
    localparam int DEPTH = fifo_depth(ASIZE);

    // Contents are deliberately not reset; occupancy tracking makes stale words invisible.
    logic [DSIZE-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    generate
        if (FALLTHROUGH == FT_FALSE) begin : g_reg
            logic [DSIZE-1:0] rdata_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)     rdata_q <= '0;
                else if (re) rdata_q <= mem_q[raddr];
            end
            assign rdata = rdata_q;
        end else begin : g_ft
            logic unused_ft;
            assign unused_ft = rst | re;
            assign rdata     = mem_q[raddr];
        end
    endgenerate

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, fill level and registered flags around sync_fifo_mem.
// Define SYNC_FIFO_ERR_EN to add sticky overflow/underflow outputs.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int    DSIZE       = 8,
    parameter int    ASIZE       = 4,
    parameter string FALLTHROUGH = FT_TRUE,
    parameter int    AFULL_TH    = 1,
    parameter int    AEMPTY_TH   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    output logic             wfull,
    output logic             awfull,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rempty,
    output logic             arempty,
    output logic [ASIZE:0]   level
`ifdef SYNC_FIFO_ERR_EN
    ,
    output logic             overflow,
    output logic             underflow
`endif
);
    localparam logic [ASIZE:0] DEPTH_W   = (ASIZE+1)'(fifo_depth(ASIZE));
    localparam logic [ASIZE:0] AFULL_W   = (ASIZE+1)'(AFULL_TH);
    localparam logic [ASIZE:0] AEMPTY_W  = (ASIZE+1)'(AEMPTY_TH);

    logic [ASIZE:0] wptr_q, wptr_d, rptr_q, rptr_d, level_q, level_d;
    fifo_flags_t    flags_q, flags_d;
    logic           wr_acc, rd_acc;

    // Acceptance uses the registered flags, so a full FIFO blocks a write even when popped that cycle.
    assign wr_acc = winc & ~flags_q.full;
    assign rd_acc = rinc & ~flags_q.empty;

    always_comb begin
        wptr_d         = wptr_q + {{ASIZE{1'b0}}, wr_acc};
        rptr_d         = rptr_q + {{ASIZE{1'b0}}, rd_acc};
        level_d        = level_q + {{ASIZE{1'b0}}, wr_acc} - {{ASIZE{1'b0}}, rd_acc};
        flags_d.full   = (wptr_d[ASIZE] != rptr_d[ASIZE]) &&
                         (wptr_d[ASIZE-1:0] == rptr_d[ASIZE-1:0]);
        flags_d.empty  = (wptr_d == rptr_d);
        flags_d.afull  = (DEPTH_W - level_d) <= AFULL_W;
        flags_d.aempty = level_d <= AEMPTY_W;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            flags_q <= '{full: 1'b0, afull: 1'b0, empty: 1'b1, aempty: 1'b1};
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            flags_q <= flags_d;
        end
    end

    assign wfull   = flags_q.full;
    assign awfull  = flags_q.afull;
    assign rempty  = flags_q.empty;
    assign arempty = flags_q.aempty;
    assign level   = level_q;

`ifdef SYNC_FIFO_ERR_EN
    logic ovf_q, udf_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_q | (winc & flags_q.full);
            udf_q <= udf_q | (rinc & flags_q.empty);
        end
    end
    assign overflow  = ovf_q;
    assign underflow = udf_q;
`endif

    sync_fifo_mem #(
        .DSIZE       (DSIZE),
        .ASIZE       (ASIZE),
        .FALLTHROUGH (FALLTHROUGH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc),
        .waddr (wptr_q[ASIZE-1:0]),
        .wdata (wdata),
        .re    (rd_acc),
        .raddr (rptr_q[ASIZE-1:0]),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: fall-through and registered instances share one stimulus stream,
// checked against a queue scoreboard and an occupancy model.
module tb_sync_fifo;
    localparam int DEPTH = 16;

    logic       clk = 1'b0, rst = 1'b1, winc = 1'b0, rinc = 1'b0;
    logic [7:0] wdata = 8'h00;

    logic       wfull_f, awfull_f, rempty_f, arempty_f;
    logic       wfull_r, awfull_r, rempty_r, arempty_r;
    logic [7:0] rdata_f, rdata_r;
    logic [4:0] level_f, level_r;
`ifdef SYNC_FIFO_ERR_EN
    logic       ovf_f, udf_f, ovf_r, udf_r;
`endif

    int         nvec = 0, nerr = 0;
    logic [7:0] sb[$];
    int         mlvl = 0;
    logic [7:0] last_reg = 8'h00;

    always #5 clk = ~clk;

    sync_fifo #(.DSIZE(8), .ASIZE(4), .FALLTHROUGH("TRUE"), .AFULL_TH(1), .AEMPTY_TH(1)) u_ft (
        .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .wfull(wfull_f), .awfull(awfull_f),
        .rinc(rinc), .rdata(rdata_f), .rempty(rempty_f), .arempty(arempty_f), .level(level_f)
`ifdef SYNC_FIFO_ERR_EN
        , .overflow(ovf_f), .underflow(udf_f)
`endif
    );

    sync_fifo #(.DSIZE(8), .ASIZE(4), .FALLTHROUGH("FALSE"), .AFULL_TH(1), .AEMPTY_TH(1)) u_reg (
        .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .wfull(wfull_r), .awfull(awfull_r),
        .rinc(rinc), .rdata(rdata_r), .rempty(rempty_r), .arempty(arempty_r), .level(level_r)
`ifdef SYNC_FIFO_ERR_EN
        , .overflow(ovf_r), .underflow(udf_r)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One clock of stimulus; scoreboard push on accepted write, pop/compare on accepted read.
    task automatic do_cycle(input bit w, input logic [7:0] d, input bit r);
        bit         wacc, racc;
        logic [7:0] exp;
        exp  = 8'h00;
        wacc = w && (mlvl < DEPTH);
        racc = r && (mlvl > 0);
        winc = w; wdata = d; rinc = r;
        if (racc) begin
            exp = sb.pop_front();
            nvec++;
            if (rdata_f !== exp) begin
                nerr++;
                $display("FAIL ft_rdata got %h want %h", rdata_f, exp);
            end
        end
        if (wacc) sb.push_back(d);
        mlvl = mlvl + int'(wacc) - int'(racc);
        step();
        winc = 1'b0; rinc = 1'b0;
        if (racc) last_reg = exp;
        nvec++;
        if (rdata_r !== last_reg) begin
            nerr++;
            $display("FAIL reg_rdata got %h want %h", rdata_r, last_reg);
        end
        nvec++;
        if (level_f !== 5'(mlvl) || level_r !== 5'(mlvl)) begin
            nerr++;
            $display("FAIL level got %0d/%0d want %0d", level_f, level_r, mlvl);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
        nvec++;
        if ({rempty_f, arempty_f, wfull_f, awfull_f} !== 4'b1100 || level_f !== 5'd0) begin
            nerr++;
            $display("FAIL reset_flags got e%b ae%b f%b af%b lvl%0d want e1 ae1 f0 af0 lvl0",
                     rempty_f, arempty_f, wfull_f, awfull_f, level_f);
        end
        nvec++;
        if (rdata_r !== 8'h00 || rempty_r !== 1'b1) begin
            nerr++;
            $display("FAIL reset_reg got rdata %h empty %b want 00 1", rdata_r, rempty_r);
        end
`ifdef SYNC_FIFO_ERR_EN
        nvec++;
        if ({ovf_f, udf_f} !== 2'b00) begin
            nerr++;
            $display("FAIL reset_err got %b%b want 00", ovf_f, udf_f);
        end
`endif
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            do_cycle(1'b1, 8'(i), 1'b0);
            if (i == 13 || i == 14 || i == 15) begin
                nvec++;
                if (awfull_f !== (i >= 14) || wfull_f !== (i == 15) || rempty_f !== 1'b0) begin
                    nerr++;
                    $display("FAIL fill_flags_%0d got af%b f%b e%b want af%b f%b e0",
                             i, awfull_f, wfull_f, rempty_f, i >= 14, i == 15);
                end
            end
        end
        do_cycle(1'b1, 8'hAA, 1'b0);
        nvec++;
        if (wfull_f !== 1'b1 || wfull_r !== 1'b1) begin
            nerr++;
            $display("FAIL overfill_full got %b/%b want 1", wfull_f, wfull_r);
        end
`ifdef SYNC_FIFO_ERR_EN
        nvec++;
        if (ovf_f !== 1'b1 || ovf_r !== 1'b1 || udf_f !== 1'b0) begin
            nerr++;
            $display("FAIL overflow got %b/%b udf %b want 1/1 0", ovf_f, ovf_r, udf_f);
        end
`endif
    endtask

    task automatic test_drain();
        for (int i = 0; i < 16; i++) begin
            do_cycle(1'b0, 8'h00, 1'b1);
            if (i >= 13) begin
                nvec++;
                if (arempty_f !== (i >= 14) || rempty_f !== (i == 15) || wfull_f !== 1'b0) begin
                    nerr++;
                    $display("FAIL drain_flags_%0d got ae%b e%b f%b want ae%b e%b f0",
                             i, arempty_f, rempty_f, wfull_f, i >= 14, i == 15);
                end
            end
        end
        do_cycle(1'b0, 8'h00, 1'b1);
        nvec++;
        if (rempty_f !== 1'b1 || rempty_r !== 1'b1) begin
            nerr++;
            $display("FAIL underread_empty got %b/%b want 1", rempty_f, rempty_r);
        end
`ifdef SYNC_FIFO_ERR_EN
        nvec++;
        if (udf_f !== 1'b1 || udf_r !== 1'b1) begin
            nerr++;
            $display("FAIL underflow got %b/%b want 1", udf_f, udf_r);
        end
`endif
    endtask

    task automatic test_registered();
        do_cycle(1'b1, 8'h5A, 1'b0);
        do_cycle(1'b0, 8'h00, 1'b1);
        nvec++;
        if (rdata_r !== 8'h5A) begin
            nerr++;
            $display("FAIL reg_pop got %h want 5a", rdata_r);
        end
        // Idle cycles and a blocked read must both leave the registered word in place.
        repeat (3) do_cycle(1'b0, 8'h00, 1'b0);
        do_cycle(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 16; i++) do_cycle(1'b1, 8'h40 + 8'(i), 1'b0);
        do_cycle(1'b1, 8'hEE, 1'b1);
        nvec++;
        if (wfull_f !== 1'b0 || awfull_f !== 1'b1) begin
            nerr++;
            $display("FAIL full_rw_flags got f%b af%b want f0 af1", wfull_f, awfull_f);
        end
        for (int i = 0; i < 15; i++) do_cycle(1'b0, 8'h00, 1'b1);
        do_cycle(1'b1, 8'h3C, 1'b1);
        nvec++;
        if (rempty_f !== 1'b0 || rdata_f !== 8'h3C) begin
            nerr++;
            $display("FAIL empty_rw got e%b rdata %h want e0 3c", rempty_f, rdata_f);
        end
        do_cycle(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) do_cycle(1'b1, 8'h80 + 8'(i), 1'b0);
        for (int i = 0; i < 100; i++) begin
            do_cycle(1'b1, 8'h88 + 8'(i), 1'b1);
            nvec++;
            if (level_f !== 5'd8 || wfull_f !== 1'b0 || rempty_f !== 1'b0) begin
                nerr++;
                $display("FAIL b2b_level_%0d got %0d f%b e%b want 8 f0 e0", i, level_f, wfull_f, rempty_f);
            end
        end
        for (int i = 0; i < 8; i++) do_cycle(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 9; i++) do_cycle(1'b1, 8'hC0 + 8'(i), 1'b0);
        do_cycle(1'b0, 8'h00, 1'b1);
        do_cycle(1'b1, 8'hD0, 1'b0);
        // Now mid-period: assert reset well away from any clock edge.
        #2;
        rst = 1'b1;
        #1;
        nvec++;
        if (level_f !== 5'd0 || level_r !== 5'd0 || {rempty_f, arempty_f, wfull_f, awfull_f} !== 4'b1100) begin
            nerr++;
            $display("FAIL async_rst got lvl%0d/%0d e%b ae%b f%b af%b want 0 e1 ae1 f0 af0",
                     level_f, level_r, rempty_f, arempty_f, wfull_f, awfull_f);
        end
        nvec++;
        if (rdata_r !== 8'h00) begin
            nerr++;
            $display("FAIL async_rst_rdata got %h want 00", rdata_r);
        end
`ifdef SYNC_FIFO_ERR_EN
        nvec++;
        if ({ovf_f, udf_f} !== 2'b00) begin
            nerr++;
            $display("FAIL async_rst_err got %b%b want 00", ovf_f, udf_f);
        end
`endif
        #2;
        rst = 1'b0;
        sb.delete();
        mlvl = 0;
        last_reg = 8'h00;
        step();
        do_cycle(1'b1, 8'h77, 1'b0);
        do_cycle(1'b0, 8'h00, 1'b1);
        nvec++;
        if (rempty_f !== 1'b1 || rdata_r !== 8'h77) begin
            nerr++;
            $display("FAIL post_rst got e%b rdata %h want e1 77", rempty_f, rdata_r);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_registered();
        test_simultaneous();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
